dm_access_ctrl: RTL and testbench

//  MEM-stage initiator for the 8-bit-addressed, big-endian, 8-byte-wide data memory.

---
 rtl/dm_access_pkg.sv | 22 ++
 rtl/dm_lane_unit.sv | 31 +++
 rtl/dm_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dm_access_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access controller.
package dm_access_pkg;

  localparam int unsigned DM_BYTES_DEF = 226;
  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 64;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_WR, ST_DONE} state_e;

  // Number of bytes moved by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] bytes_of(input size_e s);
    return 4'd1 << s;
  endfunction

  // Right-shift that brings the top S bytes of a big-endian line down to bit 0.
  function automatic logic [5:0] lane_shift(input size_e s);
    return 6'(7'd64 - {bytes_of(s), 3'b000});
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane logic: merges store data into the top of a memory line and
// extracts/extends load data from it. Purely combinational.
module dm_lane_unit
  import dm_access_pkg::*;
(
  input  logic [63:0] line,
  input  logic [63:0] wdata,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [63:0] merged_c,
  output logic [63:0] extracted_c
);

  logic [5:0]  sh;
  logic [63:0] low_ones;
  logic [63:0] top_mask;
  logic [63:0] raw;
  logic        fill;

  always_comb begin
    sh          = lane_shift(size);
    low_ones    = {64{1'b1}} >> sh;
    top_mask    = {64{1'b1}} << sh;
    // Access bytes sit at the top of the line (addr maps to [63:56]).
    merged_c    = (line & ~top_mask) | (wdata << sh);
    raw         = line >> sh;
    fill        = sign_ext && (size != SZ_D) && line[63];
    extracted_c = fill ? (raw | ~low_ones) : raw;
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage initiator for the byte-addressed, big-endian, 8-byte-wide data memory:
// one request at a time, read-modify-write for sub-doubleword stores.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int unsigned DM_BYTES = DM_BYTES_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_write_data,
  output logic              dm_mem_read,
  output logic              dm_mem_write,
  input  logic [DATA_W-1:0] dm_read_data
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  state_e            state;
  size_e             size_q;
  logic              sgn_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [EXT_W-1:0]  end_addr_c;
  logic              range_err_c;
  logic [63:0]       merged_c;
  logic [63:0]       extracted_c;

  // Last byte of the 8-byte line, computed one bit wider so 255+7 cannot wrap.
  assign end_addr_c  = {1'b0, req_addr} + EXT_W'(7);
  assign range_err_c = end_addr_c > EXT_W'(DM_BYTES - 1);

  dm_lane_unit u_lane (
    .line        (dm_read_data),
    .wdata       (wdata_q),
    .size        (size_q),
    .sign_ext    (sgn_q),
    .merged_c    (merged_c),
    .extracted_c (extracted_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      size_q        <= SZ_B;
      sgn_q         <= 1'b0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      busy          <= 1'b0;
      dm_address    <= '0;
      dm_write_data <= '0;
      dm_mem_read   <= 1'b0;
      dm_mem_write  <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            size_q    <= size_e'(req_size);
            sgn_q     <= req_signed;
            wr_q      <= req_write;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (range_err_c) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= ST_DONE;
            end else begin
              dm_address <= req_addr;
              if (req_write && (req_size == 2'd3)) begin
                dm_write_data <= req_wdata;
                dm_mem_write  <= 1'b1;
                state         <= ST_WR;
              end else begin
                dm_mem_read <= 1'b1;
                state       <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          dm_mem_read <= 1'b0;
          state       <= ST_CAP;
        end
        ST_CAP: begin
          // Read data is stable now; either finish the load or write the merged line.
          if (wr_q) begin
            dm_write_data <= merged_c;
            dm_mem_write  <= 1'b1;
            state         <= ST_WR;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extracted_c;
            state      <= ST_DONE;
          end
        end
        ST_WR: begin
          dm_mem_write <= 1'b0;
          resp_valid   <= 1'b1;
          resp_err     <= 1'b0;
          resp_rdata   <= '0;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready    <= 1'b1;
          busy         <= 1'b0;
          dm_mem_read  <= 1'b0;
          dm_mem_write <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl with a behavioural 226-byte big-endian memory.
module tb_dm_access_ctrl;

  localparam int DMB = 226;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [7:0]  dm_address;
  logic [63:0] dm_write_data;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [63:0] dm_read_data = 64'd0;

  dm_access_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .dm_address(dm_address),
    .dm_write_data(dm_write_data), .dm_mem_read(dm_mem_read),
    .dm_mem_write(dm_mem_write), .dm_read_data(dm_read_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];
  logic       rd_prev = 1'b0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         both_cnt = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Memory: captures a line on the rising read strobe, writes 8 bytes on a write strobe.
  always @(posedge clock) begin
    if (dm_mem_read && !rd_prev)
      for (int i = 0; i < 8; i++)
        dm_read_data[63-8*i -: 8] <= mem[(int'(dm_address) + i) % 256];
    rd_prev <= dm_mem_read;
    if (dm_mem_write)
      for (int i = 0; i < 8; i++)
        mem[(int'(dm_address) + i) % 256] <= dm_write_data[63-8*i -: 8];
  end

  // Response monitor: pops the scoreboard on every resp_valid pulse.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (dm_mem_read && dm_mem_write) both_cnt++;
      if (dm_mem_read) rd_cnt++;
      if (dm_mem_write) wr_cnt++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_err",   64'(resp_err), 64'(e.err));
          check("resp_rdata", resp_rdata, e.rdata);
          check("latency",    64'(cyc - acc_cyc + 1), 64'(e.lat));
          check("rd_strobes", 64'(rd_cnt), 64'(e.nrd));
          check("wr_strobes", 64'(wr_cnt), 64'(e.nwr));
        end
      end
    end
  end

  function automatic logic [63:0] exp_load(input logic [7:0] a, input logic [1:0] sz, input logic sg);
    logic [63:0] v;
    int n;
    v = '0;
    n = 1 << sz;
    for (int i = 0; i < n; i++) v = {v[55:0], ref_mem[int'(a) + i]};
    if (sg && n < 8 && ref_mem[int'(a)][7])
      for (int b = 8 * n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [7:0] a, input logic [63:0] wd);
    exp_t e;
    int n;
    int t;
    n = 1 << sz;
    e.err = (int'(a) + 7) > (DMB - 1);
    e.rdata = '0;
    if (e.err) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
    end else if (w) begin
      e.lat = (sz == 2'd3) ? 2 : 4;
      e.nrd = (sz == 2'd3) ? 0 : 1;
      e.nwr = 1;
      for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*(n-1-i) +: 8];
    end else begin
      e.lat = 3; e.nrd = 1; e.nwr = 0;
      e.rdata = exp_load(a, sz, sg);
    end
    @(negedge clock);
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!req_ready) check("ready_timeout", 64'd0, 64'd1);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    sb.push_back(e);
    @(posedge clock);
    #1;
    acc_cyc = cyc;
    rd_cnt = 0;
    wr_cnt = 0;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 30 && sb.size() != 0; t++) @(posedge clock);
    if (sb.size() != 0) begin
      check("resp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc1;
    int nmis;
    logic [7:0] save [0:7];
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    for (int i = 40; i < 48; i++) begin mem[i] = 8'h55; ref_mem[i] = 8'h55; end
    mem[80] = 8'hAA; ref_mem[80] = 8'hAA;

    repeat (3) @(negedge clock);
    check("rst_req_ready",  64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err",   64'(resp_err), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_dm_address", 64'(dm_address), 64'd0);
    check("rst_dm_wdata",   dm_write_data, 64'd0);
    check("rst_dm_strobes", 64'({dm_mem_read, dm_mem_write}), 64'd0);
    reset_n = 1'b1;

    issue(1'b0, 2'd3, 1'b0, 8'd40, 64'd0); wait_done();
    check("spec_ld_d40", resp_rdata, 64'h5555_5555_5555_5555);
    issue(1'b0, 2'd0, 1'b1, 8'd80, 64'd0); wait_done();
    check("spec_ld_b80_s", resp_rdata, 64'hFFFF_FFFF_FFFF_FFAA);
    issue(1'b0, 2'd0, 1'b0, 8'd80, 64'd0); wait_done();
    check("spec_ld_b80_u", resp_rdata, 64'h0000_0000_0000_00AA);

    issue(1'b1, 2'd1, 1'b0, 8'd40, 64'hFFFF_FFFF_FFFF_1234); wait_done();
    check("spec_st_h40_b40", 64'(mem[40]), 64'h12);
    check("spec_st_h40_b41", 64'(mem[41]), 64'h34);
    check("spec_st_h40_b42", 64'(mem[42]), 64'h55);
    check("spec_st_h40_b47", 64'(mem[47]), 64'h55);

    issue(1'b1, 2'd3, 1'b0, 8'd0, 64'h0102_0304_0506_0708); wait_done();
    check("spec_st_d0_b0", 64'(mem[0]), 64'h01);
    check("spec_st_d0_b7", 64'(mem[7]), 64'h08);
    issue(1'b0, 2'd3, 1'b1, 8'd0, 64'd0); wait_done();
    check("spec_ld_d0", resp_rdata, 64'h0102_0304_0506_0708);

    issue(1'b0, 2'd3, 1'b0, 8'd219, 64'd0); wait_done();
    issue(1'b0, 2'd3, 1'b0, 8'd218, 64'd0); wait_done();
    issue(1'b0, 2'd0, 1'b0, 8'd255, 64'd0); wait_done();
    issue(1'b1, 2'd0, 1'b0, 8'd226, 64'hFF); wait_done();

    issue(1'b1, 2'd2, 1'b0, 8'd100, 64'h0000_0000_DEAD_BEEF); wait_done();
    issue(1'b0, 2'd2, 1'b1, 8'd100, 64'd0); wait_done();
    issue(1'b0, 2'd2, 1'b0, 8'd100, 64'd0); wait_done();
    issue(1'b0, 2'd1, 1'b1, 8'd102, 64'd0); wait_done();

    // Back-to-back loads: next accept comes one idle cycle after DONE.
    issue(1'b0, 2'd1, 1'b1, 8'd40, 64'd0);
    acc1 = acc_cyc;
    issue(1'b0, 2'd2, 1'b0, 8'd41, 64'd0);
    check("b2b_gap", 64'(acc_cyc - acc1), 64'd4);
    wait_done();

    for (int k = 0; k < 30; k++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(219, 255)) : 8'($urandom_range(0, 218));
      issue(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, {$urandom, $urandom});
      wait_done();
    end

    // Reset during the write phase of a sub-doubleword store must leave memory untouched.
    for (int i = 0; i < 8; i++) save[i] = ref_mem[40 + i];
    issue(1'b1, 2'd1, 1'b0, 8'd40, 64'h0000_0000_0000_BEEF);
    for (int t = 0; t < 10 && !dm_mem_write; t++) @(negedge clock);
    check("rst_mid_reached_wr", 64'(dm_mem_write), 64'd1);
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_wr_drop", 64'(dm_mem_write), 64'd0);
    @(posedge clock);
    #1;
    check("rst_mid_busy",  64'(busy), 64'd0);
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    check("rst_mid_resp",  64'(resp_valid), 64'd0);
    for (int i = 0; i < 8; i++) ref_mem[40 + i] = save[i];
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    for (int i = 0; i < 8; i++) check("rst_mid_mem", 64'(mem[40 + i]), 64'(save[i]));

    issue(1'b0, 2'd3, 1'b0, 8'd40, 64'd0); wait_done();

    nmis = 0;
    for (int i = 0; i < DMB; i++) if (mem[i] !== ref_mem[i]) nmis++;
    check("mem_final", 64'(nmis), 64'd0);
    check("strobe_overlap", 64'(both_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
